// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - Pac-Man round flow: state machine, key decode, lives/map tracking, reset strobes.
module game_sequencer #(
  parameter int unsigned READY_FRAMES = 120,
  parameter int unsigned DEATH_FRAMES = 90,
  parameter int unsigned CLEAR_FRAMES = 120,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned NUM_MAPS     = 2
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic [7:0] kb_code,
  input  logic       kb_strobe,
  input  logic       frame_tick,
  input  logic       pacman_caught,
  input  logic       dots_cleared,
  output logic [3:0] move_dir,
  output logic [3:0] ghost_enable,
  output logic [1:0] map_num,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       freeze,
  output logic       level_reset,
  output logic       pos_reset
);

  typedef enum logic [2:0] {
    S_ATTRACT = 3'd0,
    S_READY   = 3'd1,
    S_PLAY    = 3'd2,
    S_PAUSED  = 3'd3,
    S_DYING   = 3'd4,
    S_CLEAR   = 3'd5,
    S_OVER    = 3'd6
  } state_e;

  localparam logic [7:0] READY_LAST = 8'(READY_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_FRAMES - 1);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [2:0] MAPS       = 3'(NUM_MAPS);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] lives_q, lives_d;
  logic [1:0] map_q, map_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] dir_q, dir_d;
  logic [3:0] ge_q, ge_d;
  logic       freeze_q, freeze_d;
  logic       lr_q, lr_d;
  logic       pr_q, pr_d;

  logic       key_enter, key_p, key_dir;
  logic [3:0] key_dir_val, key_set, key_clr;

  always_comb begin
    key_enter   = 1'b0;
    key_p       = 1'b0;
    key_dir     = 1'b0;
    key_dir_val = 4'b0000;
    key_set     = 4'b0000;
    key_clr     = 4'b0000;
    if (kb_strobe) begin
      case (kb_code)
        8'h5A: key_enter = 1'b1;
        8'h4D: key_p     = 1'b1;
        8'h1D: begin key_dir = 1'b1; key_dir_val = 4'b0100; end
        8'h1C: begin key_dir = 1'b1; key_dir_val = 4'b0001; end
        8'h1B: begin key_dir = 1'b1; key_dir_val = 4'b1000; end
        8'h23: begin key_dir = 1'b1; key_dir_val = 4'b0010; end
        8'h76: begin key_dir = 1'b1; key_dir_val = 4'b0000; end
        8'h05: key_set = 4'b0001;
        8'h06: key_set = 4'b0010;
        8'h04: key_set = 4'b0100;
        8'h0C: key_set = 4'b1000;
        8'h03: key_clr = 4'b0001;
        8'h0B: key_clr = 4'b0010;
        8'h83: key_clr = 4'b0100;
        8'h0A: key_clr = 4'b1000;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    map_d   = map_q;
    dir_d   = dir_q;
    mask_d  = (mask_q | key_set) & ~key_clr;
    lr_d    = 1'b0;
    pr_d    = 1'b0;

    case (state_q)
      S_ATTRACT, S_OVER: begin
        if (key_enter) begin
          state_d = S_READY;
          lives_d = LIVES_INIT;
          map_d   = 2'd0;
          lr_d    = 1'b1;
          pr_d    = 1'b1;
        end
      end
      S_READY: begin
        if (frame_tick) begin
          if (cnt_q == READY_LAST) state_d = S_PLAY;
          else                     cnt_d   = cnt_q + 8'd1;
        end
      end
      S_PLAY: begin
        if (dots_cleared) begin
          state_d = S_CLEAR;
        end else if (pacman_caught) begin
          state_d = S_DYING;
          lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
        end else if (key_p) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (key_p) state_d = S_PLAY;
      end
      S_DYING: begin
        if (frame_tick) begin
          if (cnt_q == DEATH_LAST) begin
            if (lives_q == 2'd0) begin
              state_d = S_OVER;
            end else begin
              state_d = S_READY;
              pr_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_CLEAR: begin
        if (frame_tick) begin
          if (cnt_q == CLEAR_LAST) begin
            state_d = S_READY;
            map_d   = ({1'b0, map_q} + 3'd1 >= MAPS) ? 2'd0 : map_q + 2'd1;
            lr_d    = 1'b1;
            pr_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_ATTRACT;
    endcase

    if (state_d != state_q) cnt_d = 8'd0;

    // A new round always starts stationary; steering only counts while play continues.
    if (state_d == S_READY && state_q != S_READY) begin
      dir_d = 4'b0000;
    end else if (state_q == S_PLAY && state_d == S_PLAY && key_dir) begin
      dir_d = key_dir_val;
    end

    ge_d     = (state_d == S_PLAY) ? mask_d : 4'b0000;
    freeze_d = (state_d != S_PLAY);
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state_q  <= S_ATTRACT;
      cnt_q    <= 8'd0;
      lives_q  <= LIVES_INIT;
      map_q    <= 2'd0;
      mask_q   <= 4'b0000;
      dir_q    <= 4'b0000;
      ge_q     <= 4'b0000;
      freeze_q <= 1'b1;
      lr_q     <= 1'b0;
      pr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lives_q  <= lives_d;
      map_q    <= map_d;
      mask_q   <= mask_d;
      dir_q    <= dir_d;
      ge_q     <= ge_d;
      freeze_q <= freeze_d;
      lr_q     <= lr_d;
      pr_q     <= pr_d;
    end
  end

  assign state        = state_q;
  assign move_dir     = dir_q;
  assign ghost_enable = ge_q;
  assign map_num      = map_q;
  assign lives        = lives_q;
  assign freeze       = freeze_q;
  assign level_reset  = lr_q;
  assign pos_reset    = pr_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed table-driven bench for game_sequencer.
module tb_game_sequencer;

  logic       clk_50mhz = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kb_code = 8'h00;
  logic       kb_strobe = 1'b0;
  logic       frame_tick = 1'b0;
  logic       pacman_caught = 1'b0;
  logic       dots_cleared = 1'b0;
  logic [3:0] move_dir, ghost_enable;
  logic [1:0] map_num, lives;
  logic [2:0] state;
  logic       freeze, level_reset, pos_reset;

  int n_checks = 0;
  int n_fail   = 0;
  int lr_seen  = 0;
  int pr_seen  = 0;
  logic caught_hold = 1'b0;

  game_sequencer dut (
    .clk_50mhz    (clk_50mhz),
    .rst          (rst),
    .kb_code      (kb_code),
    .kb_strobe    (kb_strobe),
    .frame_tick   (frame_tick),
    .pacman_caught(pacman_caught),
    .dots_cleared (dots_cleared),
    .move_dir     (move_dir),
    .ghost_enable (ghost_enable),
    .map_num      (map_num),
    .lives        (lives),
    .state        (state),
    .freeze       (freeze),
    .level_reset  (level_reset),
    .pos_reset    (pos_reset)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  typedef struct {
    logic       strobe;
    logic [7:0] code;
    logic       tick;
    logic       caught;
    logic       dots;
    logic [2:0] e_state;
    logic [3:0] e_dir;
    logic [3:0] e_ge;
    logic [1:0] e_lives;
    logic       e_freeze;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic s, logic [7:0] c, logic t, logic pc, logic dc,
                              logic [2:0] es, logic [3:0] ed, logic [3:0] eg,
                              logic [1:0] el, logic ef);
    vec_t v;
    v.strobe = s; v.code = c; v.tick = t; v.caught = pc; v.dots = dc;
    v.e_state = es; v.e_dir = ed; v.e_ge = eg; v.e_lives = el; v.e_freeze = ef;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after an edge, sample just after the next edge.
  task automatic cycle(input logic s, input logic [7:0] c, input logic t,
                       input logic pc, input logic dc);
    kb_strobe = s; kb_code = c; frame_tick = t;
    pacman_caught = pc | caught_hold; dots_cleared = dc;
    @(posedge clk_50mhz);
    #1;
    kb_strobe = 1'b0; frame_tick = 1'b0; pacman_caught = caught_hold; dots_cleared = 1'b0;
    lr_seen += int'(level_reset);
    pr_seen += int'(pos_reset);
  endtask

  task automatic key(input logic [7:0] c);
    cycle(1'b1, c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic death_cycle(input logic [1:0] exp_lives, input logic last);
    int pr0;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("caught_state", state, 4);
    chk("caught_lives", lives, exp_lives);
    pr0 = pr_seen;
    ticks(89);
    chk("dying_89", state, 4);
    ticks(1);
    if (last) begin
      chk("over_state", state, 6);
      chk("over_no_posreset", pr_seen - pr0, 0);
    end else begin
      chk("dying_to_ready", state, 1);
      chk("dying_posreset", pos_reset, 1);
      chk("dying_no_lvlreset", level_reset, 0);
      chk("ready_dir_zero", move_dir, 0);
      ticks(120);
      chk("replay_state", state, 2);
      chk("replay_ge", ghost_enable, 4'b0101);
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 8'h05, 0, 0, 0, 2, 4'b0000, 4'b0001, 3, 0);
    vecs[1]  = mk(1, 8'h04, 0, 0, 0, 2, 4'b0000, 4'b0101, 3, 0);
    vecs[2]  = mk(1, 8'h23, 0, 0, 0, 2, 4'b0010, 4'b0101, 3, 0);
    vecs[3]  = mk(1, 8'h1D, 0, 0, 0, 2, 4'b0100, 4'b0101, 3, 0);
    vecs[4]  = mk(1, 8'h12, 0, 0, 0, 2, 4'b0100, 4'b0101, 3, 0);
    vecs[5]  = mk(1, 8'h83, 0, 0, 0, 2, 4'b0100, 4'b0001, 3, 0);
    vecs[6]  = mk(1, 8'h04, 0, 0, 0, 2, 4'b0100, 4'b0101, 3, 0);
    vecs[7]  = mk(1, 8'h23, 0, 0, 0, 2, 4'b0010, 4'b0101, 3, 0);
    vecs[8]  = mk(1, 8'h4D, 0, 0, 0, 3, 4'b0010, 4'b0000, 3, 1);
    vecs[9]  = mk(0, 8'h00, 1, 0, 0, 3, 4'b0010, 4'b0000, 3, 1);
    vecs[10] = mk(1, 8'h1C, 0, 0, 0, 3, 4'b0010, 4'b0000, 3, 1);
    vecs[11] = mk(1, 8'h0C, 0, 0, 0, 3, 4'b0010, 4'b0000, 3, 1);
    vecs[12] = mk(1, 8'h0A, 0, 0, 0, 3, 4'b0010, 4'b0000, 3, 1);
    vecs[13] = mk(0, 8'h00, 0, 1, 1, 3, 4'b0010, 4'b0000, 3, 1);
    vecs[14] = mk(1, 8'h4D, 0, 0, 0, 2, 4'b0010, 4'b0101, 3, 0);
    vecs[15] = mk(1, 8'h76, 0, 0, 0, 2, 4'b0000, 4'b0101, 3, 0);
    vecs[16] = mk(1, 8'h1B, 0, 0, 0, 2, 4'b1000, 4'b0101, 3, 0);

    repeat (3) @(posedge clk_50mhz);
    #1;
    chk("rst_state", state, 0);
    chk("rst_lives", lives, 3);
    chk("rst_map", map_num, 0);
    chk("rst_freeze", freeze, 1);
    chk("rst_ge", ghost_enable, 0);
    chk("rst_dir", move_dir, 0);
    chk("rst_lr", level_reset, 0);
    chk("rst_pr", pos_reset, 0);
    rst = 1'b0;
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("idle_state", state, 0);
    chk("idle_freeze", freeze, 1);

    key(8'h5A);
    chk("enter_state", state, 1);
    chk("enter_lr", level_reset, 1);
    chk("enter_pr", pos_reset, 1);
    ticks(119);
    chk("ready_119", state, 1);
    chk("ready_freeze", freeze, 1);
    chk("strobe_once_lr", lr_seen, 1);
    chk("strobe_once_pr", pr_seen, 1);
    ticks(1);
    chk("ready_120", state, 2);
    chk("play_freeze", freeze, 0);

    for (int i = 0; i < 17; i++) begin
      cycle(vecs[i].strobe, vecs[i].code, vecs[i].tick, vecs[i].caught, vecs[i].dots);
      chk($sformatf("v%0d_state", i), state, vecs[i].e_state);
      chk($sformatf("v%0d_dir", i), move_dir, vecs[i].e_dir);
      chk($sformatf("v%0d_ge", i), ghost_enable, vecs[i].e_ge);
      chk($sformatf("v%0d_lives", i), lives, vecs[i].e_lives);
      chk($sformatf("v%0d_freeze", i), freeze, vecs[i].e_freeze);
    end

    death_cycle(2'd2, 1'b0);
    death_cycle(2'd1, 1'b0);
    death_cycle(2'd0, 1'b1);
    ticks(3);
    chk("over_hold", state, 6);
    key(8'h5A);
    chk("newgame_state", state, 1);
    chk("newgame_lives", lives, 3);
    chk("newgame_map", map_num, 0);
    chk("newgame_lr", level_reset, 1);
    chk("newgame_pr", pos_reset, 1);
    ticks(120);
    chk("newgame_play", state, 2);

    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("prio_state", state, 5);
    chk("prio_lives", lives, 3);
    ticks(119);
    chk("clear_119", state, 5);
    ticks(1);
    chk("clear_state", state, 1);
    chk("clear_map", map_num, 1);
    chk("clear_lr", level_reset, 1);
    chk("clear_pr", pos_reset, 1);
    ticks(120);
    chk("map1_play", state, 2);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clear2_state", state, 5);
    ticks(120);
    chk("wrap_map", map_num, 0);
    chk("wrap_state", state, 1);

    caught_hold = 1'b1;
    ticks(120);
    chk("held_caught_ready", lives, 3);
    chk("held_caught_play", state, 2);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("held_caught_die", state, 4);
    chk("held_caught_lives", lives, 2);
    caught_hold = 1'b0;
    pacman_caught = 1'b0;

    ticks(30);
    chk("mid_dying", state, 4);
    #4 rst = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_lives", lives, 3);
    chk("async_map", map_num, 0);
    chk("async_freeze", freeze, 1);
    chk("async_ge", ghost_enable, 0);
    chk("async_dir", move_dir, 0);
    chk("async_pr", pos_reset, 0);
    @(posedge clk_50mhz);
    #1 rst = 1'b0;
    ticks(5);
    chk("post_rst_state", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
